// File: rtl/uart_keypress_message_scheduler_if.sv
// Single-byte UART transmit handshake between the keypress scheduler and the transmitter.
// The scheduler drives TX_SEND/TX_DATA; the transmitter answers with TX_DONE.
interface uart_keypress_message_scheduler_if #(
    parameter int DATA_BITS = 8
);
    logic                 TX_SEND;
    logic [DATA_BITS-1:0] TX_DATA;
    logic                 TX_DONE;

    modport master (output TX_SEND, output TX_DATA, input TX_DONE);
    modport slave  (input TX_SEND, input TX_DATA, output TX_DONE);
endinterface

// File: rtl/uart_keypress_message_scheduler.sv
// Latches keypress pulses, arbitrates round-robin and sends "K<digit>\r\n" per granted key
// one byte at a time over the UART transmit handshake.
//
// state | meaning
// IDLE  | no message in progress; grants the next pending key
// SEND  | TX_SEND cycle for byte[byte_idx]
// WAIT  | holding TX_DATA until the transmitter reports TX_DONE
module uart_keypress_message_scheduler #(
    parameter int NUM_KEYS  = 4,
    parameter int DATA_BITS = 8
) (
    input  logic                  CLK,
    input  logic                  RESET,
    input  logic [NUM_KEYS-1:0]   KEY_PRESS,
    uart_keypress_message_scheduler_if.master tx,
    output logic                  BUSY,
    output logic                  OVERRUN
);
    localparam int PTR_W = (NUM_KEYS > 1) ? $clog2(NUM_KEYS) : 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SEND = 2'd1,
        WAIT = 2'd2
    } state_t;

    state_t               state, state_next;
    logic [NUM_KEYS-1:0]  pend;
    logic [NUM_KEYS-1:0]  grant_mask;
    logic [PTR_W-1:0]     ptr, ptr_next;
    logic [PTR_W-1:0]     winner;
    logic [PTR_W-1:0]     cur_key, cur_key_next;
    logic [1:0]           byte_idx, byte_idx_next;
    logic                 grant;
    logic [7:0]           byte_next;

    function automatic logic [7:0] msg_byte(input logic [1:0] idx, input logic [PTR_W-1:0] key);
        case (idx)
            2'd0:    msg_byte = 8'h4B;
            2'd1:    msg_byte = 8'h30 + 8'(key);
            2'd2:    msg_byte = 8'h0D;
            default: msg_byte = 8'h0A;
        endcase
    endfunction

    // First pending key at or after ptr, wrapping around.
    always_comb begin : pick_winner
        logic             found;
        logic [PTR_W-1:0] cand;
        found  = 1'b0;
        cand   = '0;
        winner = '0;
        for (int i = 0; i < NUM_KEYS; i++) begin
            cand = PTR_W'((32'(ptr) + 32'(i)) % 32'(NUM_KEYS));
            if (!found && pend[cand]) begin
                found  = 1'b1;
                winner = cand;
            end
        end
    end

    always_comb begin
        state_next    = state;
        grant         = 1'b0;
        ptr_next      = ptr;
        cur_key_next  = cur_key;
        byte_idx_next = byte_idx;
        case (state)
            IDLE: begin
                if (|pend) begin
                    grant         = 1'b1;
                    cur_key_next  = winner;
                    byte_idx_next = 2'd0;
                    ptr_next      = PTR_W'((32'(winner) + 32'd1) % 32'(NUM_KEYS));
                    state_next    = SEND;
                end
            end
            SEND: state_next = WAIT;
            WAIT: begin
                if (tx.TX_DONE) begin
                    if (byte_idx == 2'd3) begin
                        state_next = IDLE;
                    end else begin
                        byte_idx_next = byte_idx + 2'd1;
                        state_next    = SEND;
                    end
                end
            end
            default: state_next = IDLE;
        endcase
        grant_mask = grant ? (NUM_KEYS'(1) << winner) : '0;
        byte_next  = msg_byte(byte_idx_next, cur_key_next);
    end

    // Set wins over grant-clear, so a press on the key being granted is re-queued silently.
    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            state      <= IDLE;
            pend       <= '0;
            ptr        <= '0;
            cur_key    <= '0;
            byte_idx   <= '0;
            tx.TX_SEND <= 1'b0;
            tx.TX_DATA <= '0;
            BUSY       <= 1'b0;
            OVERRUN    <= 1'b0;
        end else begin
            state      <= state_next;
            pend       <= (pend & ~grant_mask) | KEY_PRESS;
            ptr        <= ptr_next;
            cur_key    <= cur_key_next;
            byte_idx   <= byte_idx_next;
            tx.TX_SEND <= (state_next == SEND);
            if (state_next == SEND) begin
                tx.TX_DATA <= DATA_BITS'(byte_next);
            end
            BUSY       <= (state_next != IDLE);
            OVERRUN    <= |(KEY_PRESS & pend & ~grant_mask);
        end
    end
endmodule

// File: tb/tb_uart_keypress_message_scheduler.sv
// Directed and randomized checks of the keypress message scheduler against a byte-queue model.
module tb_uart_keypress_message_scheduler;
    localparam int NK = 4;

    logic          CLK;
    logic          RESET;
    logic [NK-1:0] KEY_PRESS;
    logic          BUSY;
    logic          OVERRUN;

    uart_keypress_message_scheduler_if #(.DATA_BITS(8)) tx_if ();

    uart_keypress_message_scheduler #(.NUM_KEYS(NK), .DATA_BITS(8)) dut (
        .CLK       (CLK),
        .RESET     (RESET),
        .KEY_PRESS (KEY_PRESS),
        .tx        (tx_if.master),
        .BUSY      (BUSY),
        .OVERRUN   (OVERRUN)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    int n_cmp = 0;
    int n_err = 0;

    // Model: pending flags, rr pointer, and the bytes still owed for the current message.
    bit         m_pend [NK];
    int         m_ptr;
    int         m_q [$];
    bit         m_sending;
    bit         m_wait;
    bit         exp_send;
    logic [7:0] exp_data;
    bit         exp_busy;
    bit         exp_ov;

    int tx_cnt;
    int tx_delay;
    int n_sends;
    int n_k2;
    int n_ov;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp)
        else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < NK; i++) m_pend[i] = 1'b0;
        m_ptr = 0;
        m_q.delete();
        m_sending = 1'b0;
        m_wait    = 1'b0;
        exp_send  = 1'b0;
        exp_data  = 8'h00;
        exp_busy  = 1'b0;
        exp_ov    = 1'b0;
    endtask

    task automatic model_step(input logic [NK-1:0] p, input bit d);
        int g;
        g = -1;
        exp_ov = 1'b0;
        exp_send = 1'b0;
        if (!m_sending && !m_wait && m_q.size() == 0) begin
            for (int i = 0; i < NK; i++) begin
                if (g < 0 && m_pend[(m_ptr + i) % NK]) g = (m_ptr + i) % NK;
            end
        end
        for (int i = 0; i < NK; i++) begin
            if (p[i] && m_pend[i] && i != g) exp_ov = 1'b1;
        end
        if (g >= 0) m_pend[g] = 1'b0;
        for (int i = 0; i < NK; i++) begin
            if (p[i]) m_pend[i] = 1'b1;
        end
        if (g >= 0) begin
            m_ptr = (g + 1) % NK;
            m_q = '{8'h4B, 8'h30 + g, 8'h0D, 8'h0A};
            exp_data = 8'(m_q.pop_front());
            exp_send = 1'b1;
            m_sending = 1'b1;
        end else if (m_sending) begin
            m_sending = 1'b0;
            m_wait    = 1'b1;
        end else if (m_wait && d) begin
            m_wait = 1'b0;
            if (m_q.size() > 0) begin
                exp_data  = 8'(m_q.pop_front());
                exp_send  = 1'b1;
                m_sending = 1'b1;
            end
        end
        exp_busy = m_sending || m_wait || (m_q.size() > 0);
    endtask

    task automatic check_outputs();
        chk("tx_send", 32'(tx_if.TX_SEND), 32'(exp_send));
        chk("tx_data", 32'(tx_if.TX_DATA), 32'(exp_data));
        chk("busy",    32'(BUSY),          32'(exp_busy));
        chk("overrun", 32'(OVERRUN),       32'(exp_ov));
    endtask

    // One clock: drive at negedge, model the edge, compare at the following negedge.
    task automatic tick(input logic [NK-1:0] p, input bit spur);
        bit d;
        d = (tx_cnt == 1) || spur;
        KEY_PRESS     = p;
        tx_if.TX_DONE = d;
        @(posedge CLK);
        model_step(p, d);
        if (tx_cnt > 0) tx_cnt--;
        @(negedge CLK);
        check_outputs();
        if (tx_if.TX_SEND === 1'b1) begin
            tx_cnt = tx_delay;
            n_sends++;
            if (tx_if.TX_DATA === 8'h32) n_k2++;
        end
        if (OVERRUN === 1'b1) n_ov++;
    endtask

    task automatic idle_ticks(input int n);
        for (int i = 0; i < n; i++) tick('0, 1'b0);
    endtask

    task automatic do_reset();
        KEY_PRESS     = '0;
        tx_if.TX_DONE = 1'b0;
        #2 RESET = 1'b0;
        #1;
        chk("rst_tx_send", 32'(tx_if.TX_SEND), 32'd0);
        chk("rst_tx_data", 32'(tx_if.TX_DATA), 32'd0);
        chk("rst_busy",    32'(BUSY),          32'd0);
        chk("rst_overrun", 32'(OVERRUN),       32'd0);
        @(posedge CLK);
        @(negedge CLK);
        RESET = 1'b1;
        model_reset();
        tx_cnt = 0;
    endtask

    initial begin
        RESET         = 1'b0;
        KEY_PRESS     = '0;
        tx_if.TX_DONE = 1'b0;
        tx_cnt        = 0;
        tx_delay      = 10;
        model_reset();
        @(negedge CLK);
        do_reset();

        // Single press of key 2.
        n_sends = 0;
        tick(4'b0100, 1'b0);
        idle_ticks(60);
        chk("single_sends", 32'(n_sends), 32'd4);

        // Simultaneous keys 0 and 3 from reset.
        do_reset();
        n_sends = 0;
        tick(4'b1001, 1'b0);
        idle_ticks(110);
        chk("simul_sends", 32'(n_sends), 32'd8);

        // Round robin: key1, then 0/1/2 pressed mid-message.
        do_reset();
        n_sends = 0;
        tick(4'b0010, 1'b0);
        idle_ticks(5);
        tick(4'b0111, 1'b0);
        idle_ticks(220);
        chk("rr_sends", 32'(n_sends), 32'd16);

        // Overrun: key2 twice while key0 transmits.
        do_reset();
        n_sends = 0;
        n_k2 = 0;
        n_ov = 0;
        tick(4'b0001, 1'b0);
        idle_ticks(5);
        tick(4'b0100, 1'b0);
        idle_ticks(3);
        tick(4'b0100, 1'b0);
        idle_ticks(120);
        chk("ovr_pulses", 32'(n_ov), 32'd1);
        chk("ovr_k2_once", 32'(n_k2), 32'd1);

        // Reset during WAIT of byte1, then silence, then key3.
        n_sends = 0;
        tick(4'b0001, 1'b0);
        idle_ticks(15);
        do_reset();
        n_sends = 0;
        idle_ticks(20);
        chk("post_rst_quiet", 32'(n_sends), 32'd0);
        tick(4'b1000, 1'b0);
        idle_ticks(60);
        chk("post_rst_k3", 32'(n_sends), 32'd4);

        // Spurious TX_DONE in IDLE and in the SEND cycle.
        n_sends = 0;
        tick('0, 1'b1);
        tick(4'b0001, 1'b0);
        tick('0, 1'b0);
        tick('0, 1'b1);
        idle_ticks(60);
        chk("spur_sends", 32'(n_sends), 32'd4);

        // Randomized traffic with random transmitter latency, stray TX_DONE and resets.
        for (int c = 0; c < 3000; c++) begin
            logic [NK-1:0] p;
            p = ($urandom_range(0, 9) == 0) ? NK'($urandom_range(0, 15)) : '0;
            tx_delay = $urandom_range(1, 8);
            if ($urandom_range(0, 799) == 0) do_reset();
            else tick(p, $urandom_range(0, 29) == 0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule

// File: doc/uart_keypress_message_scheduler.md
# uart_keypress_message_scheduler

Sequences multi-byte keypress reports onto the single-byte UART transmit path. It latches single-cycle keypress events from up to NUM_KEYS debounced keys and arbitrates among them round-robin. For each granted key it emits the 4-byte ASCII message "K", digit, CR, LF through the transmitter's TX_SEND/TX_DATA/TX_DONE handshake. It sits between the key debouncers and the UART keypress reporter, and is the only driver of the reporter's TX inputs.

## Interface
- NUM_KEYS, 4, number of key inputs; legal range 1..10 (digit must be '0'..'9').
- DATA_BITS, 8, width of TX_DATA; must be ≥ 7 (ASCII); upper bits beyond 7 are zero.

- CLK  input  1  system clock; all state updates on rising edge.
- RESET  input  1  asynchronous, active-low reset (0 = reset asserted).
- KEY_PRESS  input  NUM_KEYS  one-cycle press pulses, one bit per key; any combination may pulse in the same cycle.
- TX_SEND  output  1  one-cycle request to transmit TX_DATA.
- TX_DATA  output  DATA_BITS  byte to send; valid from the TX_SEND cycle until TX_DONE.
- TX_DONE  input  1  one-cycle pulse from the transmitter when the current byte's stop bit is complete.
- BUSY  output  1  high while a message is in progress (state ≠ IDLE).
- OVERRUN  output  1  one-cycle pulse when a press arrives for a key whose report is already pending.

## Operation
- Pending register pend[NUM_KEYS-1:0]:
  - A KEY_PRESS bit sets its pend bit.
  - A grant clears the granted bit.
  - Set wins over clear in the same cycle. The key is then re-reported later, with no OVERRUN.
- OVERRUN:
  - Asserts when KEY_PRESS[i] and pend[i] are both already 1 and bit i is not being granted that cycle.
  - Pulses from multiple keys OR into a single pulse.
  - The press is dropped; it is never queued twice.
- Pressing the key whose message is currently transmitting (its pend bit already cleared) sets pend normally, so the key is reported again.
- Round-robin pointer ptr (0..NUM_KEYS-1), reset value 0:
  - The winner is the first set pend bit scanning ptr, ptr+1, … with wrap-around mod NUM_KEYS.
  - On grant, ptr ← winner+1 mod NUM_KEYS.
- Message bytes for granted key k: byte0 = 0x4B ('K'), byte1 = 0x30+k, byte2 = 0x0D, byte3 = 0x0A.
- FSM states:
  - IDLE:
    - If pend ≠ 0: latch cur_key = winner, clear pend[winner], byte_idx ← 0, update ptr, go to SEND.
    - Otherwise stay in IDLE.
  - SEND: TX_SEND = 1 for exactly this cycle; TX_DATA = byte[byte_idx]; go to WAIT.
  - WAIT: hold TX_DATA.
    - On TX_DONE with byte_idx = 3 → IDLE.
    - On TX_DONE with byte_idx < 3 → byte_idx+1, SEND.
    - Otherwise stay in WAIT. No timeout.
- TX_DONE received in IDLE or SEND is ignored.
- Reset values (asynchronous, while RESET = 0):
  - state = IDLE, pend = 0, ptr = 0, byte_idx = 0, cur_key = 0.
  - TX_SEND = 0, TX_DATA = 0, BUSY = 0, OVERRUN = 0.
- Reset mid-message:
  - The message is abandoned and all pending presses are lost.
  - After release, the block returns to IDLE with no TX_SEND until a new press.
  - TX_DATA returns to 0.
- All outputs are registered.

## Timing
- Press sampled at edge N:
  - pend visible after N.
  - Grant at edge N+1.
  - TX_SEND high in the cycle following edge N+1 (2-edge latency).
  - BUSY rises with the grant.
- Between bytes: TX_DONE sampled at edge M → TX_SEND for the next byte is high in the cycle after M.
- Between messages:
  - Final TX_DONE at edge M → IDLE.
  - Next grant at M+1.
  - Next TX_SEND in the cycle after M+1.
  - BUSY drops for exactly one cycle if another key is pending.
- OVERRUN is high in the cycle after the offending KEY_PRESS edge.
- One message is exactly 4 TX_SEND pulses. TX_SEND is never asserted in WAIT or in IDLE.
- Minimum gap from TX_DONE to the next TX_SEND is 1 cycle; the transmitter must accept that.

## Test plan
- Single press: KEY_PRESS = 4'b0100 for one cycle, transmitter model returns TX_DONE 10 cycles after each TX_SEND → TX_DATA sequence 0x4B, 0x32, 0x0D, 0x0A. Exactly 4 TX_SEND pulses; BUSY high throughout, then 0.
- Simultaneous presses: KEY_PRESS = 4'b1001 in one cycle from reset → full key0 message ("K0\r\n") then full key3 message ("K3\r\n"). ptr ends at 0.
- Round-robin: serve key1 alone, then during its message press keys 0, 1, 2 → following messages in order K2, K0, K1.
- Overrun: press key2 twice while key0 is transmitting → one OVERRUN pulse on the second press; key2 reported exactly once.
- Reset mid-message: pull RESET low during WAIT of byte1 → outputs 0 immediately; after release, no TX_SEND until a new press. A new key3 press yields "K3\r\n".
- Spurious TX_DONE: pulse TX_DONE in IDLE and in the SEND cycle → no state change, byte_idx unaffected, message bytes still sent in order.
